// File: rtl/disp_pkg.sv
// Shared definitions for the register display path: glyph codes, line geometry, sequencer states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Port summary: none. Provides R_CODE/SPACE_CODE/COLON_CODE, LINE_CHARS,
// the sequencer state enum and a helper that maps a hex-digit column to its
// nibble slot within the latched register value.
package disp_pkg;

    localparam logic [7:0] R_CODE     = 8'd52;
    localparam logic [7:0] SPACE_CODE = 8'd53;
    localparam logic [7:0] COLON_CODE = 8'd54;

    // 'R', index, ':', ' ', then 8 hex digits
    localparam int LINE_CHARS = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CAPTURE,
        S_EMIT,
        S_NEXT
    } state_t;

    // Column 4 shows the top nibble (slot 7), column 11 the bottom nibble (slot 0).
    function automatic logic [2:0] nibble_slot(input logic [3:0] col);
        return 3'(4'(LINE_CHARS - 1) - col);
    endfunction

endpackage

// File: rtl/nibble_to_glyph.sv
// Maps a 4-bit nibble to the glyph code of its hex digit (glyphs 0..15 are the digits 0..F).
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_nibble - value 0..15; o_glyph - 8-bit glyph code.
module nibble_to_glyph (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_glyph
);

    assign o_glyph = {4'b0000, i_nibble};

endmodule

// File: rtl/reg_char_sequencer.sv
// Walks the register file and streams one 12-glyph line per register ("Rn: XXXXXXXX").
// Latency: start in cycle N -> first char_valid in cycle N+READ_LATENCY+3.
// Backpressure: char_code/row/col held while char_valid && !char_ready; valid never drops without a transfer.
//
// Ports: clock/reset (sync, active-high); start begins a pass; addr/register_value
// are the register-file read port; char_valid/char_ready/char_code/char_row/char_col
// form the glyph stream; busy marks a pass; finished_register pulses once per line.
// Build option: CONTINUOUS_REFRESH_EN makes the scan wrap to register 0 forever.
module reg_char_sequencer
    import disp_pkg::*;
#(
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] register_value,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [7:0]        char_code,
    output logic [3:0]        char_row,
    output logic [3:0]        char_col,
    output logic              busy,
    output logic              finished_register
);

    state_t            r_state;
    logic [3:0]        r_idx;
    logic [1:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_val;

    logic              w_xfer;
    logic              w_last_reg;
    logic [3:0]        w_sel_col;
    logic [DATA_W-1:0] w_shifted;
    logic [3:0]        w_nib;
    logic [7:0]        w_nib_glyph;
    logic [7:0]        w_next_code;

    assign w_xfer     = char_valid & char_ready;
    assign w_last_reg = (r_idx == 4'(NUM_REGS - 1));

    // Column whose glyph gets registered next: 0 when a line opens, else the following one.
    assign w_sel_col = (r_state == S_CAPTURE) ? 4'd0 : char_col + 4'd1;
    assign w_shifted = r_val >> {nibble_slot(w_sel_col), 2'b00};
    assign w_nib     = (w_sel_col == 4'd1) ? r_idx : w_shifted[3:0];

    nibble_to_glyph u_nibble_to_glyph (
        .i_nibble (w_nib),
        .o_glyph  (w_nib_glyph)
    );

    always_comb begin
        w_next_code = w_nib_glyph;
        case (w_sel_col)
            4'd0:    w_next_code = R_CODE;
            4'd2:    w_next_code = COLON_CODE;
            4'd3:    w_next_code = SPACE_CODE;
            default: w_next_code = w_nib_glyph;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_idx             <= 4'd0;
            r_wait_cnt        <= 2'd0;
            r_val             <= '0;
            addr              <= '0;
            char_valid        <= 1'b0;
            char_code         <= 8'd0;
            char_row          <= 4'd0;
            char_col          <= 4'd0;
            busy              <= 1'b0;
            finished_register <= 1'b0;
        end else begin
            finished_register <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= 4'd0;
                        addr    <= '0;
                        busy    <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_wait_cnt <= 2'd0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // WAIT always takes one cycle plus READ_LATENCY-1 extra cycles.
                    if (r_wait_cnt == 2'(READ_LATENCY - 1)) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                S_CAPTURE: begin
                    r_val      <= register_value;
                    char_valid <= 1'b1;
                    char_code  <= w_next_code;
                    char_row   <= r_idx;
                    char_col   <= 4'd0;
                    r_state    <= S_EMIT;
                end
                S_EMIT: begin
                    if (w_xfer) begin
                        if (char_col == 4'(LINE_CHARS - 1)) begin
                            char_valid        <= 1'b0;
                            finished_register <= 1'b1;
                            r_state           <= S_NEXT;
                        end else begin
                            char_col  <= char_col + 4'd1;
                            char_code <= w_next_code;
                        end
                    end
                end
                S_NEXT: begin
                    if (w_last_reg) begin
`ifdef CONTINUOUS_REFRESH_EN
                        r_idx   <= 4'd0;
                        addr    <= '0;
                        r_state <= S_FETCH;
`else
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
`endif
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        addr    <= ADDR_W'(r_idx + 4'd1);
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_char_sequencer.sv
// Bench for reg_char_sequencer: expected glyphs queued at stimulus time, popped by monitors on transfer.
// Latency: n/a.
// Backpressure: bench drives char_ready low for 5 cycles in one pass.
module tb_reg_char_sequencer;

    int checks = 0;
    int errors = 0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // main instance: defaults (8 registers, read latency 1)
    logic        start = 1'b0;
    logic [8:0]  addr;
    logic [31:0] register_value = 32'd0;
    logic        char_valid;
    logic        char_ready = 1'b1;
    logic [7:0]  char_code;
    logic [3:0]  char_row;
    logic [3:0]  char_col;
    logic        busy;
    logic        finished_register;

    // second instance: one register, read latency 3
    logic        start3 = 1'b0;
    logic [8:0]  addr3;
    logic [31:0] rv3 = 32'hAAAA_AAAA;
    logic        cv3;
    logic [7:0]  code3;
    logic [3:0]  row3;
    logic [3:0]  col3;
    logic        busy3;
    logic        fin3;

    logic [31:0] rf [8];

    logic [15:0] q [$];
    logic [15:0] q3 [$];
    logic [8:0]  fin_addrs [$];
    int          n_glyphs = 0;
    int          n_fin3 = 0;

    byte unsigned exp_dead [12] = '{52, 0, 54, 53, 13, 14, 10, 13, 11, 14, 14, 15};
    byte unsigned exp_1to8 [12] = '{52, 0, 54, 53, 1, 2, 3, 4, 5, 6, 7, 8};

    always #5 clock = ~clock;

    reg_char_sequencer u_dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .addr              (addr),
        .register_value    (register_value),
        .char_valid        (char_valid),
        .char_ready        (char_ready),
        .char_code         (char_code),
        .char_row          (char_row),
        .char_col          (char_col),
        .busy              (busy),
        .finished_register (finished_register)
    );

    reg_char_sequencer #(.NUM_REGS(1), .READ_LATENCY(3)) u_dut3 (
        .clock             (clock),
        .reset             (reset),
        .start             (start3),
        .addr              (addr3),
        .register_value    (rv3),
        .char_valid        (cv3),
        .char_ready        (1'b1),
        .char_code         (code3),
        .char_row          (row3),
        .char_col          (col3),
        .busy              (busy3),
        .finished_register (fin3)
    );

    // register file with one clock of read latency
    always @(posedge clock) register_value <= rf[addr[2:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // row 0 shows DEADBEEF; row r>0 holds value r, so digits are 0000000r
    task automatic push_pass();
        for (int c = 0; c < 12; c++) q.push_back({exp_dead[c], 4'd0, 4'(c)});
        for (int r = 1; r < 8; r++) begin
            q.push_back({8'd52, 4'(r), 4'd0});
            q.push_back({8'(r), 4'(r), 4'd1});
            q.push_back({8'd54, 4'(r), 4'd2});
            q.push_back({8'd53, 4'(r), 4'd3});
            for (int c = 4; c < 11; c++) q.push_back({8'd0, 4'(r), 4'(c)});
            q.push_back({8'(r), 4'(r), 4'd11});
        end
    endtask

    // main monitor: scoreboard pop, hold-under-stall check, finished_register log
    logic        prev_stall = 1'b0;
    logic [16:0] prev_snap = '0;
    always @(negedge clock) begin
        logic [15:0] e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_under_stall", {15'd0, char_valid, char_code, char_row, char_col},
                    {15'd0, prev_snap});
            if (char_valid && char_ready) begin
                n_glyphs++;
                if (q.size() == 0) begin
                    chk("unexpected_glyph", {16'd0, char_code, char_row, char_col}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("glyph", {16'd0, char_code, char_row, char_col}, {16'd0, e});
                end
            end
            if (finished_register) fin_addrs.push_back(addr);
            prev_stall = char_valid && !char_ready;
            prev_snap  = {char_valid, char_code, char_row, char_col};
        end
    end

    always @(negedge clock) begin
        logic [15:0] e;
        if (!reset) begin
            if (cv3) begin
                if (q3.size() == 0) begin
                    chk("unexpected_glyph3", {16'd0, code3, row3, col3}, 32'hFFFF_FFFF);
                end else begin
                    e = q3.pop_front();
                    chk("glyph3", {16'd0, code3, row3, col3}, {16'd0, e});
                end
            end
            if (fin3) n_fin3++;
        end
    end

    // one full pass on the main instance; optional stall at row 2 col 6 and mid-pass start
    task automatic run_pass(input bit stress, output int first_vld, output int busy_cyc);
        int cyc;
        int bp_left;
        bit bp_done;
        bp_left = 0;
        bp_done = 0;
        first_vld = -1;
        busy_cyc = 0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 2000) begin
            if (stress) begin
                start = (cyc == 50);
                if (bp_left > 0) begin
                    bp_left--;
                    if (bp_left == 0) char_ready = 1'b1;
                end else if (!bp_done && char_valid && char_row == 4'd2 && char_col == 4'd6) begin
                    char_ready = 1'b0;
                    bp_left = 5;
                    bp_done = 1;
                end
            end
            if (char_valid && first_vld < 0) first_vld = cyc;
            if (!busy) break;
            busy_cyc++;
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0;
        char_ready = 1'b1;
        if (cyc >= 2000) chk("pass_timeout", 1, 0);
    endtask

    task automatic check_pass_end(input int busy_exp, input int busy_cyc);
        chk("busy_cycles", busy_cyc, busy_exp);
        chk("glyph_count", n_glyphs, 96);
        chk("leftover_expected", q.size(), 0);
        chk("finished_pulses", fin_addrs.size(), 8);
        for (int i = 0; i < 8 && i < fin_addrs.size(); i++) chk("addr_seq", fin_addrs[i], i);
    endtask

    initial begin
        int first_vld;
        int busy_cyc;
        int cyc;

        rf[0] = 32'hDEAD_BEEF;
        for (int i = 1; i < 8; i++) rf[i] = i;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_addr", addr, 0);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_char_code", char_code, 0);
        chk("rst_char_row", char_row, 0);
        chk("rst_char_col", char_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished_register, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // full pass, ready tied high
        push_pass();
        n_glyphs = 0;
        fin_addrs.delete();
        run_pass(1'b0, first_vld, busy_cyc);
        chk("first_valid_latency", first_vld, 4);
        check_pass_end(128, busy_cyc);
        chk("busy_low_after_pass", busy, 0);

        // pass with 5-cycle stall at row 2 col 6 and a start pulse mid-pass
        repeat (3) @(posedge clock); #1;
        push_pass();
        n_glyphs = 0;
        fin_addrs.delete();
        run_pass(1'b1, first_vld, busy_cyc);
        check_pass_end(133, busy_cyc);
        repeat (20) @(posedge clock); #1;
        chk("no_queued_start", busy, 0);

        // reset during EMIT of row 1
        push_pass();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (!(char_valid && char_row == 4'd1 && char_col == 4'd3) && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (cyc >= 200) chk("reach_row1_timeout", 1, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midrst_char_valid", char_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_col", char_col, 0);
        q.delete();
        repeat (5) @(posedge clock); #1;
        chk("idle_after_rst", {30'd0, busy, char_valid}, 0);

        // latency-3 instance: value changes one cycle before CAPTURE, then again after
        for (int c = 0; c < 12; c++) q3.push_back({exp_1to8[c], 4'd0, 4'(c)});
        n_fin3 = 0;
        first_vld = -1;
        busy_cyc = 0;
        start3 = 1'b1;
        @(posedge clock); #1;
        start3 = 1'b0;
        cyc = 1;
        while (cyc < 500) begin
            if (cyc == 4) rv3 = 32'h1234_5678;
            if (cyc == 6) rv3 = 32'h0;
            if (cv3 && first_vld < 0) first_vld = cyc;
            if (!busy3) break;
            busy_cyc++;
            @(posedge clock); #1;
            cyc++;
        end
        if (cyc >= 500) chk("pass3_timeout", 1, 0);
        chk("first_valid_latency3", first_vld, 6);
        chk("busy_cycles3", busy_cyc, 18);
        chk("leftover_expected3", q3.size(), 0);
        chk("finished_pulses3", n_fin3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
